// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, feeder state type and lane helper for the MAC array front end
package mac_pkg;

  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int DRAIN  = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } feed_state_e;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/feeder_buf.sv
// rtl/feeder_buf.sv - NxN register file, one write port, N row-indexed read ports
module feeder_buf #(
  parameter  int N      = 4,
  parameter  int DATA_W = 8,
  localparam int IW     = $clog2(N)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [IW-1:0]       wr_row_i,
  input  logic [IW-1:0]       wr_col_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [N*IW-1:0]     rd_col_i,
  output logic [N*DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [N][N];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mem_q[r][c] <= '0;
    end else if (we_i) begin
      mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  // Read port r returns row r; a write on the same edge is forwarded so a run
  // started together with a write already sees the new value.
  always_comb begin
    rd_data_o = '0;
    for (int r = 0; r < N; r++) begin
      if (we_i && wr_row_i == IW'(r) && wr_col_i == rd_col_i[r*IW +: IW])
        rd_data_o[r*DATA_W +: DATA_W] = wr_data_i;
      else
        rd_data_o[r*DATA_W +: DATA_W] = mem_q[r][rd_col_i[r*IW +: IW]];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - feature/weight buffers and skewed wavefront feeder for the 4x4 MAC array
module systolic_feeder #(
  parameter  int N      = mac_pkg::N,
  parameter  int DATA_W = mac_pkg::DATA_W,
  parameter  int ACC_W  = mac_pkg::ACC_W,
  parameter  int DRAIN  = mac_pkg::DRAIN,
  localparam int IW     = $clog2(N)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [IW-1:0]       wr_row,
  input  logic [IW-1:0]       wr_col,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_err,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [N*DATA_W-1:0] act_out,
  output logic                act_valid,
  output logic [N*DATA_W-1:0] w_out,
  output logic                w_load,
  output logic [IW-1:0]       w_col,
  output logic [ACC_W-1:0]    carry_in
);
  import mac_pkg::*;

  localparam int CW = $clog2(2*N + DRAIN);

  feed_state_e         state_q;
  logic [CW-1:0]       cnt_q;
  logic                wr_err_q, busy_q, done_q, act_valid_q, w_load_q;
  logic [N*DATA_W-1:0] act_q, w_out_q;
  logic [IW-1:0]       w_col_q;
  logic [ACC_W-1:0]    carry_q;

  logic                idle_w, feed_w, last_t_w, w_ld_d;
  logic [CW-1:0]       t_d;
  logic [N*IW-1:0]     f_col, w_rcol;
  logic [N*DATA_W-1:0] f_rd, w_rd, act_d, w_out_d;

  assign idle_w   = (state_q == S_IDLE);
  assign last_t_w = (cnt_q == CW'(2*N - 1));
  assign feed_w   = (idle_w && start) || (state_q == S_STREAM && !last_t_w);

  feeder_buf #(.N(N), .DATA_W(DATA_W)) u_fbuf (
    .clk_i(clock), .rst_ni(reset), .we_i(wr_en && idle_w && !wr_sel),
    .wr_row_i(wr_row), .wr_col_i(wr_col), .wr_data_i(wr_data),
    .rd_col_i(f_col), .rd_data_o(f_rd)
  );

  feeder_buf #(.N(N), .DATA_W(DATA_W)) u_wbuf (
    .clk_i(clock), .rst_ni(reset), .we_i(wr_en && idle_w && wr_sel),
    .wr_row_i(wr_row), .wr_col_i(wr_col), .wr_data_i(wr_data),
    .rd_col_i(w_rcol), .rd_data_o(w_rd)
  );

  // t_d is the stream step the next edge loads; lane j lags lane 0 by j steps.
  always_comb begin
    t_d    = (state_q == S_STREAM) ? cnt_q + CW'(1) : '0;
    f_col  = '0;
    w_rcol = '0;
    act_d  = '0;
    for (int j = 0; j < N; j++) begin
      f_col[j*IW +: IW]  = IW'(t_d - CW'(j));
      w_rcol[j*IW +: IW] = IW'(t_d);
      if (t_d >= CW'(j) && (t_d - CW'(j)) < CW'(N))
        act_d[lane_lo(j, DATA_W) +: DATA_W] = f_rd[lane_lo(j, DATA_W) +: DATA_W];
    end
    w_ld_d  = (t_d < CW'(N));
    w_out_d = w_ld_d ? w_rd : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_err_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      act_valid_q <= 1'b0;
      act_q       <= '0;
      w_out_q     <= '0;
      w_load_q    <= 1'b0;
      w_col_q     <= '0;
      carry_q     <= '0;
    end else begin
      wr_err_q    <= wr_en && !idle_w;
      done_q      <= 1'b0;
      carry_q     <= '0;
      act_valid_q <= feed_w;
      act_q       <= feed_w ? act_d : '0;
      w_out_q     <= feed_w ? w_out_d : '0;
      w_load_q    <= feed_w && w_ld_d;
      w_col_q     <= (feed_w && w_ld_d) ? IW'(t_d) : '0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_STREAM;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
        S_STREAM: if (last_t_w) begin
          state_q <= S_DRAIN;
          cnt_q   <= '0;
        end else begin
          cnt_q <= t_d;
        end
        S_DRAIN: if (cnt_q == CW'(DRAIN - 1)) begin
          state_q <= S_DONE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_err    = wr_err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign act_out   = act_q;
  assign act_valid = act_valid_q;
  assign w_out     = w_out_q;
  assign w_load    = w_load_q;
  assign w_col     = w_col_q;
  assign carry_in  = carry_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - self-checking bench for systolic_feeder against a wavefront model
module tb_systolic_feeder;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 24;
  localparam int DR  = 5;
  localparam int IW  = 2;
  localparam int RUN = 2*N + DR + 1;

  logic clock = 1'b0, reset = 1'b0, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [IW-1:0] wr_row = '0, wr_col = '0;
  logic [DW-1:0] wr_data = '0;
  logic wr_err, busy, done, act_valid, w_load;
  logic [N*DW-1:0] act_out, w_out;
  logic [IW-1:0] w_col;
  logic [AW-1:0] carry_in;

  int compared = 0, mismatched = 0;
  int mf[N][N];
  int mw[N][N];

  logic [N*DW-1:0] cap_act[RUN], cap_w[RUN];
  logic            cap_valid[RUN], cap_load[RUN], cap_busy[RUN], cap_done[RUN];
  logic [IW-1:0]   cap_col[RUN];
  logic [AW-1:0]   cap_carry[RUN];

  always #5 clock = ~clock;

  systolic_feeder dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .wr_err(wr_err), .start(start), .busy(busy),
    .done(done), .act_out(act_out), .act_valid(act_valid), .w_out(w_out),
    .w_load(w_load), .w_col(w_col), .carry_in(carry_in)
  );

  // Wavefront step t: lane j carries F[j][t-j] when that column exists.
  function automatic logic [N*DW-1:0] exp_act(input int t);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j*DW +: DW] = DW'(mf[j][t-j]);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] exp_w(input int t);
    logic [N*DW-1:0] v;
    v = '0;
    if (t < N)
      for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(mw[i][t]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_buf(input bit sel, input int r, input int c, input int v);
    wr_en = 1'b1; wr_sel = sel; wr_row = IW'(r); wr_col = IW'(c); wr_data = DW'(v);
    tick();
    wr_en = 1'b0;
    if (sel) mw[r][c] = v; else mf[r][c] = v;
  endtask

  task automatic load_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_buf(1'b0, r, c, int'($urandom_range(0, 255)));
        write_buf(1'b1, r, c, int'($urandom_range(0, 255)));
      end
  endtask

  task automatic clear_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mf[r][c] = 0;
        mw[r][c] = 0;
      end
  endtask

  task automatic capture_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < RUN; c++) begin
      cap_act[c] = act_out; cap_w[c] = w_out; cap_valid[c] = act_valid;
      cap_load[c] = w_load; cap_col[c] = w_col; cap_busy[c] = busy;
      cap_done[c] = done; cap_carry[c] = carry_in;
      tick();
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_timeout done=%b required 1", name, done);
    end
    tick();
  endtask

  task automatic test_reset();
    load_random();
    #2 reset = 1'b0;
    #1;
    compared++;
    if ({act_out, w_out, act_valid, w_load, w_col, busy, done, wr_err, carry_in} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs act=%h w=%h busy=%b done=%b required all 0", act_out, w_out, busy, done);
    end
    tick();
    reset = 1'b1;
    clear_model();
    capture_run();
    for (int c = 0; c < RUN; c++) begin
      compared++;
      if (cap_act[c] !== '0 || cap_w[c] !== '0) begin
        mismatched++;
        $display("FAIL reset_cleared c=%0d act=%h w=%h required 0", c, cap_act[c], cap_w[c]);
      end
    end
  endtask

  task automatic test_directed();
    int frow[N][N] = '{'{4,0,2,1}, '{4,3,2,0}, '{4,3,0,1}, '{4,3,2,1}};
    int lanes[N][2*N] = '{'{4,0,2,1,0,0,0,0}, '{0,4,3,2,0,0,0,0},
                          '{0,0,4,3,0,1,0,0}, '{0,0,0,4,3,2,1,0}};
    logic [N*DW-1:0] ea, ew;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_buf(1'b0, r, c, frow[r][c]);
        write_buf(1'b1, r, c, c + 1);
      end
    capture_run();
    for (int t = 0; t < 2*N; t++) begin
      ea = '0; ew = '0;
      for (int j = 0; j < N; j++) begin
        ea[j*DW +: DW] = DW'(lanes[j][t]);
        if (t < N) ew[j*DW +: DW] = DW'(t + 1);
      end
      compared++;
      if (cap_act[t] !== ea || cap_w[t] !== ew || cap_col[t] !== IW'(t < N ? t : 0)) begin
        mismatched++;
        $display("FAIL directed_t%0d act=%h w=%h col=%0d required act=%h w=%h", t, cap_act[t], cap_w[t], cap_col[t], ea, ew);
      end
    end
  endtask

  task automatic test_timing();
    capture_run();
    for (int c = 0; c < RUN; c++) begin
      compared++;
      if (cap_busy[c] !== (c < 2*N + DR) || cap_done[c] !== (c == RUN - 1) ||
          cap_valid[c] !== (c < 2*N) || cap_load[c] !== (c < N) || cap_carry[c] !== '0) begin
        mismatched++;
        $display("FAIL timing_c%0d busy=%b done=%b valid=%b load=%b carry=%h required busy=%b done=%b valid=%b load=%b carry=0",
                 c, cap_busy[c], cap_done[c], cap_valid[c], cap_load[c], cap_carry[c],
                 c < 2*N + DR, c == RUN - 1, c < 2*N, c < N);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      load_random();
      capture_run();
      for (int c = 0; c < RUN; c++) begin
        compared++;
        if (cap_act[c] !== exp_act(c) || cap_w[c] !== exp_w(c)) begin
          mismatched++;
          $display("FAIL random%0d_c%0d act=%h w=%h required act=%h w=%h", it, c, cap_act[c], cap_w[c], exp_act(c), exp_w(c));
        end
      end
    end
  endtask

  task automatic test_write_with_start();
    for (int s = 0; s < 2; s++) begin
      int r, v;
      r = (s == 0) ? 0 : int'($urandom_range(0, N-1));
      v = int'($urandom_range(0, 255));
      wr_en = 1'b1; wr_sel = s[0]; wr_row = IW'(r); wr_col = '0; wr_data = DW'(v);
      start = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0;
      if (s == 0) mf[r][0] = v; else mw[r][0] = v;
      compared++;
      if (act_out !== exp_act(0) || w_out !== exp_w(0)) begin
        mismatched++;
        $display("FAIL write_with_start_sel%0d act=%h w=%h required act=%h w=%h", s, act_out, w_out, exp_act(0), exp_w(0));
      end
      wait_done("write_with_start");
    end
  endtask

  task automatic test_wr_err();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = DW'(mf[0][0] ^ 8'hFF);
    tick();
    wr_en = 1'b0;
    compared++;
    if (wr_err !== 1'b1) begin
      mismatched++;
      $display("FAIL wr_err_pulse wr_err=%b required 1", wr_err);
    end
    tick();
    compared++;
    if (wr_err !== 1'b0) begin
      mismatched++;
      $display("FAIL wr_err_clear wr_err=%b required 0", wr_err);
    end
    wait_done("wr_err");
    capture_run();
    for (int c = 0; c < RUN; c++) begin
      compared++;
      if (cap_act[c] !== exp_act(c) || cap_w[c] !== exp_w(c)) begin
        mismatched++;
        $display("FAIL wr_err_replay_c%0d act=%h w=%h required act=%h w=%h", c, cap_act[c], cap_w[c], exp_act(c), exp_w(c));
      end
    end
  endtask

  // start held high: DONE, then one IDLE cycle that accepts the next start.
  task automatic test_back_to_back();
    int o;
    start = 1'b1;
    tick();
    for (int c = 0; c < 2*(RUN + 1); c++) begin
      o = c % (RUN + 1);
      compared++;
      if (act_out !== exp_act(o) || done !== (o == RUN - 1) || busy !== (o < RUN - 1)) begin
        mismatched++;
        $display("FAIL back_to_back_c%0d act=%h done=%b busy=%b required act=%h done=%b busy=%b",
                 c, act_out, done, busy, exp_act(o), o == RUN - 1, o < RUN - 1);
      end
      if (c == 2*(RUN + 1) - 1) start = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    compared++;
    if ({act_out, w_out, act_valid, w_load, w_col, busy, done} !== '0) begin
      mismatched++;
      $display("FAIL midrun_async act=%h w=%h valid=%b busy=%b required all 0", act_out, w_out, act_valid, busy);
    end
    tick();
    reset = 1'b1;
    clear_model();
    for (int c = 0; c < RUN; c++) begin
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL midrun_no_done c=%0d done=%b busy=%b required 0 0", c, done, busy);
      end
      tick();
    end
    capture_run();
    for (int c = 0; c < RUN; c++) begin
      compared++;
      if (cap_act[c] !== '0 || cap_w[c] !== '0) begin
        mismatched++;
        $display("FAIL midrun_cleared c=%0d act=%h w=%h required 0", c, cap_act[c], cap_w[c]);
      end
    end
  endtask

  initial begin
    clear_model();
    tick();
    tick();
    reset = 1'b1;
    tick();
    test_reset();
    test_directed();
    test_timing();
    test_random();
    test_write_with_start();
    test_wr_err();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the 4x4 systolic MAC/quantise/ReLU array.
- Holds an NxN feature buffer and an NxN weight buffer, loaded over a simple write port.
- On start, loads one weight column per cycle into the array and emits the diagonally skewed activation wavefront, then zero-flushes the pipeline.
- Drives the array's activation lanes (a11..a14), weight inputs (wij) and carry_in.

Parameters:
- N, 4, array dimension (lanes and rows).
- DATA_W, 8, activation/weight width.
- ACC_W, 24, carry_in width into the array.
- DRAIN, 5, extra all-zero cycles after the wavefront, covering the array pipeline depth.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_sel  in  1  0 = feature buffer, 1 = weight buffer.
- wr_row  in  $clog2(N)  buffer row index.
- wr_col  in  $clog2(N)  buffer column index.
- wr_data  in  DATA_W  write data.
- wr_err  out  1  one-cycle pulse: write rejected because not IDLE.
- start  in  1  begin one feed sequence.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse at end of DRAIN.
- act_out  out  N*DATA_W  lane j = bits [j*DATA_W +: DATA_W], drives a1(j+1).
- act_valid  out  1  high during STREAM.
- w_out  out  N*DATA_W  slot i = weight for array row i+1, current column.
- w_load  out  1  high while w_out is meaningful.
- w_col  out  $clog2(N)  column index being loaded.
- carry_in  out  ACC_W  constant 0 while running; 0 at reset.

Behaviour:
- Reset (reset low, async): FSM to IDLE; both buffers cleared to 0; every output 0.
- All outputs are registered.
- Writes:
  - Accepted only in IDLE with wr_en=1. Write buf[wr_sel][wr_row][wr_col] = wr_data at the edge.
  - wr_en=1 outside IDLE: no write; wr_err=1 the next cycle.
- FSM: IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 at edge k moves to STREAM; t=0 outputs appear after edge k. start while not IDLE is ignored. start and wr_en together in IDLE: the write takes effect, then start is accepted, so a write issued with start is used by that sequence.
- STREAM, counter t = 0..2N-1 (2N cycles):
  - act_valid=1.
  - act lane j = F[j][t-j] if 0 <= t-j < N, else 0.
  - t<N: w_load=1, w_col=t, w_out slot i = W[i][t].
  - t>=N: w_load=0, w_out=0.
  - t=2N-1 is an all-zero activation cycle.
- DRAIN: DRAIN cycles. act_out=0, act_valid=0, w_load=0; counter reused.
- DONE: one cycle. done=1, busy=0, then IDLE.
- busy=1 in STREAM and DRAIN.
- Sequence length: 2N + DRAIN + 1 cycles, i.e. 14 cycles at defaults.
- Buffers are not modified by a run, so back-to-back runs replay the same data.
- Reset mid-run: immediate abort; buffers are zero afterwards; no done pulse.
- Counter width: $clog2(2N + DRAIN); no wrap inside a state.

Decomposition:
- Shared package (mac_pkg):
  - DATA_W, ACC_W, N localparams.
  - FSM state enum {IDLE, STREAM, DRAIN, DONE}.
  - Lane-slice helper function.
- One sub-module, feeder_buf: NxN register file with one write port and N combinational read ports (row-indexed or column-indexed). Instantiated twice: feature buffer and weight buffer.
- FSM, skew index arithmetic and output registers stay in systolic_feeder.

Test Plan:
- Reset with buffers preloaded then reset low -> all outputs 0, then a run emits only zeros on act_out and w_out.
- Setup: load F rows [4,0,2,1],[4,3,2,0],[4,3,0,1],[4,3,2,1] and all W rows [1,2,3,4], then pulse start.
  - Lane sequence t=0..7: lane0 = 4,0,2,1,0,0,0,0; lane1 = 0,4,3,2,0,0,0,0; lane2 = 0,0,4,3,0,1,0,0; lane3 = 0,0,0,4,3,2,1,0.
  - w_out = {1,1,1,1},{2,2,2,2},{3,3,3,3},{4,4,4,4} with w_col 0..3.
- Same run, timing -> done pulses exactly 14 cycles after start is sampled; busy high for 13 cycles; carry_in stays 0.
- wr_en=1 at t=2 -> wr_err pulse next cycle; a second run reproduces the identical lane sequence.
- start held high continuously -> runs back-to-back with one DONE cycle between them; start during STREAM does not restart the counter.
- reset low at t=3 -> outputs 0 asynchronously, no done pulse; after release a run emits only zeros (buffers cleared).
